// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the chart feed: scheduler state encoding, lane count
// and the default timing constants also used by the renderer and hit judge.
package note_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_t;

  localparam int LANES           = 4;
  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_STEP_HZ = 50;

  function automatic int tick_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Bundle between the note scheduler, the chart ROM and the lane renderer.
interface note_scheduler_if #(
  parameter int ADDR_W = 13
);

  // note_valid and step_tick are one-cycle pushes with no ready: the renderer
  // must take every strobe. rom_data carries no handshake and is treated as
  // valid ROM_LAT cycles after rom_addr last changed.
  logic [ADDR_W-1:0]                   rom_addr;
  logic [note_scheduler_pkg::LANES-1:0] rom_data;
  logic [note_scheduler_pkg::LANES-1:0] note;
  logic                                note_valid;
  logic                                step_tick;
  logic [2:0]                          row_phase;
  logic                                playing;
  logic                                song_done;

  modport master (
    output rom_addr, note, note_valid, step_tick, row_phase, playing, song_done,
    input  rom_data
  );

  modport slave (
    input  rom_addr, note, note_valid, step_tick, row_phase, playing, song_done,
    output rom_data
  );

endinterface

// File: rtl/note_scheduler_tick_divider.sv
// Modulo-N counter with enable and synchronous clear; tick is high during the
// enabled cycle in which the count wraps from N-1 back to 0.
module note_scheduler_tick_divider #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Walks the chart ROM, prefetches the next note row and emits the scroll-step
// and row-advance strobes that keep the lane renderer in step with the scroll.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int CLK_HZ        = DEFAULT_CLK_HZ,
  parameter int STEP_HZ       = DEFAULT_STEP_HZ,
  parameter int STEPS_PER_ROW = 5,
  parameter int CHART_LEN     = 4096,
  parameter int ADDR_W        = 13,
  parameter int ROM_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    pause,
  note_scheduler_if.master        bus,
  output sched_state_t            state_dbg
);

  localparam int                TICK_DIV   = tick_div(CLK_HZ, STEP_HZ);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CHART_LEN - 1);
  localparam logic [2:0]        LAST_PHASE = 3'(STEPS_PER_ROW - 1);
  localparam logic [1:0]        LAT        = 2'(ROM_LAT);

  sched_state_t      state, state_nx;
  logic [ADDR_W-1:0] rom_addr;
  logic [LANES-1:0]  note, next_row;
  logic              note_valid, step_tick;
  logic [2:0]        row_phase;
  logic              tail;
  logic              pf_busy;
  logic [1:0]        pf_cnt;
  logic              run, launch, wrap, advance, pf_done;

  // The resume cycle out of PAUSED already counts, so a pause of N cycles
  // delays every later strobe by exactly N cycles.
  assign run     = ((state == ST_PLAY) || (state == ST_PAUSED)) && !pause;
  assign launch  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign pf_done = pf_busy && (pf_cnt == LAT);
  assign advance = wrap && (row_phase == LAST_PHASE);

  note_scheduler_tick_divider #(
    .N (TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .resetn (resetn),
    .en     (run),
    .clr    (launch),
    .tick   (wrap)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_FETCH;
      ST_FETCH:         if (pf_done) state_nx = ST_PLAY;
      ST_PLAY: begin
        if (advance && tail) state_nx = ST_DONE;
        else if (pause)      state_nx = ST_PAUSED;
      end
      ST_PAUSED:        if (!pause) state_nx = (advance && tail) ? ST_DONE : ST_PLAY;
      default:          state_nx = ST_IDLE;
    endcase
  end

  // tail marks that the final chart row has been emitted; the next advance
  // flushes a blank row and ends the song.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rom_addr   <= '0;
      note       <= '0;
      next_row   <= '0;
      note_valid <= 1'b0;
      step_tick  <= 1'b0;
      row_phase  <= '0;
      tail       <= 1'b0;
      pf_busy    <= 1'b0;
      pf_cnt     <= '0;
    end else begin
      step_tick  <= wrap;
      note_valid <= advance;
      if (launch) begin
        rom_addr  <= '0;
        row_phase <= '0;
        tail      <= 1'b0;
        pf_busy   <= 1'b1;
        pf_cnt    <= '0;
      end else begin
        if (pf_busy) begin
          if (pf_done) begin
            next_row <= bus.rom_data;
            pf_busy  <= 1'b0;
          end else begin
            pf_cnt <= pf_cnt + 1'b1;
          end
        end
        if (wrap) begin
          row_phase <= advance ? 3'd0 : row_phase + 3'd1;
        end
        if (advance) begin
          if (tail) begin
            note <= '0;
          end else begin
            note <= next_row;
            if (rom_addr == LAST_ADDR) begin
              tail <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              pf_busy  <= 1'b1;
              pf_cnt   <= '0;
            end
          end
        end
      end
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.note       = note;
  assign bus.note_valid = note_valid;
  assign bus.step_tick  = step_tick;
  assign bus.row_phase  = row_phase;
  assign bus.playing    = (state == ST_PLAY) || (state == ST_PAUSED);
  assign bus.song_done  = (state == ST_DONE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: a ROM_LAT=1 instance covers start, play,
// flush, pause, reset and held start; a ROM_LAT=3 instance covers deep prefetch.
module tb_note_scheduler;
  import note_scheduler_pkg::*;

  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic start  = 1'b0;
  logic pause  = 1'b0;
  logic start3 = 1'b0;
  logic pause3 = 1'b0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sched_state_t st1, st3;

  note_scheduler_if #(.ADDR_W(AW)) bus1 ();
  note_scheduler_if #(.ADDR_W(AW)) bus3 ();

  note_scheduler #(
    .CLK_HZ(200), .STEP_HZ(50), .STEPS_PER_ROW(5), .CHART_LEN(3), .ADDR_W(AW), .ROM_LAT(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .bus(bus1.master), .state_dbg(st1)
  );

  note_scheduler #(
    .CLK_HZ(200), .STEP_HZ(50), .STEPS_PER_ROW(5), .CHART_LEN(3), .ADDR_W(AW), .ROM_LAT(3)
  ) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .pause(pause3), .bus(bus3.master), .state_dbg(st3)
  );

  // ---------------- chart ROM models (registered address pipes) ----------------
  logic [3:0]    rom_img [4] = '{4'h8, 4'h3, 4'hF, 4'h0};
  logic [AW-1:0] p1;
  logic [AW-1:0] p3 [3];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p1 <= '0; p3[0] <= '0; p3[1] <= '0; p3[2] <= '0;
    end else begin
      p1    <= bus1.rom_addr;
      p3[0] <= bus3.rom_addr;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  assign bus1.rom_data = rom_img[p1];
  assign bus3.rom_data = rom_img[p3[2]];

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  task automatic launch(input bit sel3, output int t0);
    if (sel3) start3 = 1'b1;
    else      start  = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_strobe(input bit sel3, input bit want_note, input int t0,
                             output int rel, output logic [3:0] nt);
    logic hit;
    rel = -1;
    nt  = 4'hx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel3) hit = want_note ? bus3.note_valid : bus3.step_tick;
      else      hit = want_note ? bus1.note_valid : bus1.step_tick;
      if (hit) begin
        rel = cyc - t0 - 1;
        nt  = sel3 ? bus3.note : bus1.note;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus1.step_tick || bus1.note_valid) cnt++;
    end
  endtask

  task automatic play_notes(input bit sel3, input int t0, input int first_rel, input string tag);
    int         rel;
    logic [3:0] nt;
    logic [3:0] exp;
    exp_q.delete();
    exp_q.push_back(4'h8);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hF);
    exp_q.push_back(4'h0);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(sel3, 1'b1, t0, rel, nt);
      exp = exp_q.pop_front();
      check($sformatf("%s_note%0d", tag, i), 32'(nt), 32'(exp));
      check($sformatf("%s_time%0d", tag, i), rel, first_rel + 20 * i);
    end
    check({tag, "_song_done"}, sel3 ? bus3.song_done : bus1.song_done, 1);
    check({tag, "_playing"},   sel3 ? bus3.playing   : bus1.playing,   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         t0, rel, cnt;
    logic [3:0] nt;

    repeat (3) @(negedge clk);
    check("rst_rom_addr",   bus1.rom_addr,   0);
    check("rst_note",       bus1.note,       0);
    check("rst_note_valid", bus1.note_valid, 0);
    check("rst_step_tick",  bus1.step_tick,  0);
    check("rst_row_phase",  bus1.row_phase,  0);
    check("rst_playing",    bus1.playing,    0);
    check("rst_song_done",  bus1.song_done,  0);
    check("rst_state",      st1,             ST_IDLE);
    resetn = 1'b1;
    @(negedge clk);

    // basic song: first tick, three rows, flush
    launch(1'b0, t0);
    check("s1_state_fetch", st1, ST_FETCH);
    wait_strobe(1'b0, 1'b0, t0, rel, nt);
    check("s1_first_tick", rel, 6);
    play_notes(1'b0, t0, 22, "s1");

    // quiet after end of song
    count_strobes(100, cnt);
    check("s2_no_strobes", cnt, 0);
    check("s2_song_done",  bus1.song_done, 1);
    check("s2_note_zero",  bus1.note, 0);
    check("s2_rom_addr",   bus1.rom_addr, 2);

    // 37-cycle pause at row_phase 2
    launch(1'b0, t0);
    wait_strobe(1'b0, 1'b0, t0, rel, nt);
    wait_strobe(1'b0, 1'b0, t0, rel, nt);
    check("s3_tick2_time", rel, 10);
    @(negedge clk);
    check("s3_phase_before", bus1.row_phase, 2);
    pause = 1'b1;
    count_strobes(37, cnt);
    check("s3_no_strobes", cnt, 0);
    check("s3_phase_held", bus1.row_phase, 2);
    check("s3_state",      st1, ST_PAUSED);
    check("s3_playing",    bus1.playing, 1);
    pause = 1'b0;
    play_notes(1'b0, t0, 59, "s3");

    // asynchronous reset mid-play
    launch(1'b0, t0);
    wait_strobe(1'b0, 1'b1, t0, rel, nt);
    check("s4_first_note", 32'(nt), 32'h8);
    wait_strobe(1'b0, 1'b0, t0, rel, nt);
    wait_strobe(1'b0, 1'b0, t0, rel, nt);
    check("s4_phase_pre", bus1.row_phase, 2);
    #1 resetn = 1'b0;
    #1;
    check("s4_rst_rom_addr",  bus1.rom_addr,  0);
    check("s4_rst_note",      bus1.note,      0);
    check("s4_rst_row_phase", bus1.row_phase, 0);
    check("s4_rst_playing",   bus1.playing,   0);
    check("s4_rst_state",     st1,            ST_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    count_strobes(40, cnt);
    check("s4_no_strobes", cnt, 0);
    check("s4_idle", st1, ST_IDLE);
    launch(1'b0, t0);
    play_notes(1'b0, t0, 22, "s4");

    // start held high through play, then replay from DONE
    start = 1'b1;
    t0 = cyc;
    play_notes(1'b0, t0, 22, "s5a");
    @(negedge clk);
    check("s5_restart_state", st1, ST_FETCH);
    check("s5_restart_addr",  bus1.rom_addr, 0);
    check("s5_restart_done",  bus1.song_done, 0);
    start = 1'b0;
    play_notes(1'b0, t0 + 83, 22, "s5b");

    // three-cycle ROM latency
    launch(1'b1, t0);
    wait_strobe(1'b1, 1'b0, t0, rel, nt);
    check("s6_first_tick", rel, 8);
    play_notes(1'b1, t0, 24, "s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
